// File: rtl/axi_lite_intc_multi.sv
// AXI4-Lite interrupt controller slave: up to 32 sources,
// runtime edge/level sensitivity, software trigger, one irq.
module axi_lite_intc_multi #(
  parameter int          C_NUM_OF_INTR          = 4,
  parameter logic [31:0] C_INTR_SENSITIVITY_RST = 32'hFFFFFFFF,
  parameter logic [31:0] C_INTR_ACTIVE_STATE    = 32'hFFFFFFFF,
  parameter bit          C_IRQ_SENSITIVITY      = 1'b1,
  parameter bit          C_IRQ_ACTIVE_STATE     = 1'b1
) (
  input  logic                     s_axi_intr_aclk,
  input  logic                     s_axi_intr_aresetn,
  input  logic [4:0]               s_axi_intr_awaddr,
  input  logic                     s_axi_intr_awvalid,
  output logic                     s_axi_intr_awready,
  input  logic [31:0]              s_axi_intr_wdata,
  input  logic [3:0]               s_axi_intr_wstrb,
  input  logic                     s_axi_intr_wvalid,
  output logic                     s_axi_intr_wready,
  output logic [1:0]               s_axi_intr_bresp,
  output logic                     s_axi_intr_bvalid,
  input  logic                     s_axi_intr_bready,
  input  logic [4:0]               s_axi_intr_araddr,
  input  logic                     s_axi_intr_arvalid,
  output logic                     s_axi_intr_arready,
  output logic [31:0]              s_axi_intr_rdata,
  output logic [1:0]               s_axi_intr_rresp,
  output logic                     s_axi_intr_rvalid,
  input  logic                     s_axi_intr_rready,
  input  logic [C_NUM_OF_INTR-1:0] irq_src,
  output logic                     irq
);

  localparam int N = C_NUM_OF_INTR;
  localparam logic [N-1:0] ACT_POL  = C_INTR_ACTIVE_STATE[N-1:0];
  localparam logic [N-1:0] SENS_RST = C_INTR_SENSITIVITY_RST[N-1:0];

  logic         gie;
  logic [N-1:0] ier;
  logic [N-1:0] status;
  logic [N-1:0] sens;
  logic [N-1:0] prevAct;
  logic         bvalidQ;
  logic         rvalidQ;
  logic [31:0]  rdataQ;
  logic         anyPrev;
  logic         irqQ;

  logic         wrAccept;
  logic         rdAccept;
  logic [31:0]  wrMask;
  logic [31:0]  wrBits;
  logic [7:0]   wrHit;
  logic [7:0]   rdHit;
  logic [N-1:0] act;
  logic [N-1:0] evt;
  logic [N-1:0] iackClr;
  logic [N-1:0] swSet;
  logic [N-1:0] pend;
  logic         any;
  logic [31:0]  rdMux;
  logic         unusedBits;

  assign wrAccept = s_axi_intr_awvalid & s_axi_intr_wvalid & ~bvalidQ;
  assign rdAccept = s_axi_intr_arvalid & ~rvalidQ;

  // Readies are combinational; keep them quiet while reset is held.
  assign s_axi_intr_awready = wrAccept & s_axi_intr_aresetn;
  assign s_axi_intr_wready  = wrAccept & s_axi_intr_aresetn;
  assign s_axi_intr_arready = rdAccept & s_axi_intr_aresetn;
  assign s_axi_intr_bvalid  = bvalidQ;
  assign s_axi_intr_rvalid  = rvalidQ;
  assign s_axi_intr_rdata   = rdataQ;
  assign s_axi_intr_bresp   = 2'b00;
  assign s_axi_intr_rresp   = 2'b00;

  assign wrMask = {{8{s_axi_intr_wstrb[3]}}, {8{s_axi_intr_wstrb[2]}},
                   {8{s_axi_intr_wstrb[1]}}, {8{s_axi_intr_wstrb[0]}}};
  assign wrBits = s_axi_intr_wdata & wrMask;
  assign wrHit  = wrAccept ? (8'b1 << s_axi_intr_awaddr[4:2]) : 8'b0;
  assign rdHit  = 8'b1 << s_axi_intr_araddr[4:2];

  assign act     = irq_src ~^ ACT_POL;
  assign evt     = (sens & act & ~prevAct) | (~sens & act);
  assign iackClr = wrHit[3] ? wrBits[N-1:0] : '0;
  assign swSet   = wrHit[6] ? wrBits[N-1:0] : '0;
  assign pend    = status & ier;
  assign any     = gie & (|pend);

  assign unusedBits = ^{s_axi_intr_awaddr[1:0], s_axi_intr_araddr[1:0],
                        wrBits};

  always_comb begin
    rdMux = '0;
    unique case (1'b1)
      rdHit[0]: rdMux = {31'b0, gie};
      rdHit[1]: rdMux = 32'(ier);
      rdHit[2]: rdMux = 32'(status);
      rdHit[4]: rdMux = 32'(pend);
      rdHit[5]: rdMux = 32'(sens);
      default:  rdMux = '0;
    endcase
  end

  always_ff @(posedge s_axi_intr_aclk or negedge s_axi_intr_aresetn) begin
    if (!s_axi_intr_aresetn) begin
      gie     <= 1'b0;
      ier     <= '0;
      status  <= '0;
      sens    <= SENS_RST;
      prevAct <= '0;
      bvalidQ <= 1'b0;
      rvalidQ <= 1'b0;
      rdataQ  <= '0;
      anyPrev <= 1'b0;
      irqQ    <= 1'b0;
    end else begin
      prevAct <= act;
      // Set beats clear when an event and an IACK hit together.
      status  <= (status & ~iackClr) | evt | swSet;
      unique case (1'b1)
        wrHit[0]: if (s_axi_intr_wstrb[0]) gie <= s_axi_intr_wdata[0];
        wrHit[1]: ier  <= (ier & ~wrMask[N-1:0]) | wrBits[N-1:0];
        wrHit[5]: sens <= (sens & ~wrMask[N-1:0]) | wrBits[N-1:0];
        default: ;
      endcase
      if (wrAccept)
        bvalidQ <= 1'b1;
      else if (s_axi_intr_bready)
        bvalidQ <= 1'b0;
      if (rdAccept) begin
        rvalidQ <= 1'b1;
        rdataQ  <= rdMux;
      end else if (s_axi_intr_rready) begin
        rvalidQ <= 1'b0;
      end
      anyPrev <= any;
      irqQ    <= C_IRQ_SENSITIVITY ? any : (any & ~anyPrev);
    end
  end

  assign irq = C_IRQ_ACTIVE_STATE ? irqQ : ~irqQ;

endmodule

// File: tb/tb_axi_lite_intc_multi.sv
// Randomised bench for axi_lite_intc_multi against a
// behavioural model; level and pulse irq instances side by side.
module tb_axi_lite_intc_multi;

  localparam int N = 4;
  localparam logic [31:0] NM  = 32'hF;
  localparam logic [31:0] ACT = 32'hFFFFFFFF;

  logic        tb_ACLK;
  logic        rstN;
  logic [4:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [4:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [N-1:0] irqSrc;
  logic        irqL;

  logic        pAwready, pWready, pBvalid, pArready, pRvalid, pIrq;
  logic [1:0]  pBresp, pRresp;
  logic [31:0] pRdata;

  int nVec;
  int nErr;
  int pulseCnt;

  logic        mGie;
  logic [31:0] mIer, mStatus, mSens, mPrev, mRdata;
  logic        mAnyPrev, mIrqL, mIrqP, mBvalid, mRvalid;

  axi_lite_intc_multi #(.C_NUM_OF_INTR(N)) dut (
    .s_axi_intr_aclk(tb_ACLK), .s_axi_intr_aresetn(rstN),
    .s_axi_intr_awaddr(awaddr), .s_axi_intr_awvalid(awvalid),
    .s_axi_intr_awready(awready), .s_axi_intr_wdata(wdata),
    .s_axi_intr_wstrb(wstrb), .s_axi_intr_wvalid(wvalid),
    .s_axi_intr_wready(wready), .s_axi_intr_bresp(bresp),
    .s_axi_intr_bvalid(bvalid), .s_axi_intr_bready(bready),
    .s_axi_intr_araddr(araddr), .s_axi_intr_arvalid(arvalid),
    .s_axi_intr_arready(arready), .s_axi_intr_rdata(rdata),
    .s_axi_intr_rresp(rresp), .s_axi_intr_rvalid(rvalid),
    .s_axi_intr_rready(rready), .irq_src(irqSrc), .irq(irqL));

  axi_lite_intc_multi #(.C_NUM_OF_INTR(N), .C_IRQ_SENSITIVITY(1'b0)) dutP (
    .s_axi_intr_aclk(tb_ACLK), .s_axi_intr_aresetn(rstN),
    .s_axi_intr_awaddr(awaddr), .s_axi_intr_awvalid(awvalid),
    .s_axi_intr_awready(pAwready), .s_axi_intr_wdata(wdata),
    .s_axi_intr_wstrb(wstrb), .s_axi_intr_wvalid(wvalid),
    .s_axi_intr_wready(pWready), .s_axi_intr_bresp(pBresp),
    .s_axi_intr_bvalid(pBvalid), .s_axi_intr_bready(bready),
    .s_axi_intr_araddr(araddr), .s_axi_intr_arvalid(arvalid),
    .s_axi_intr_arready(pArready), .s_axi_intr_rdata(pRdata),
    .s_axi_intr_rresp(pRresp), .s_axi_intr_rvalid(pRvalid),
    .s_axi_intr_rready(rready), .irq_src(irqSrc), .irq(pIrq));

  initial tb_ACLK = 1'b0;
  always #5 tb_ACLK = ~tb_ACLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nErr++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] regRead(input logic [4:0] a);
    case (a[4:2])
      3'd0: return {31'b0, mGie};
      3'd1: return mIer;
      3'd2: return mStatus;
      3'd4: return mStatus & mIer;
      3'd5: return mSens;
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: one step per clock, from the register-map rules.
  always @(posedge tb_ACLK or negedge rstN) begin
    logic        any, a;
    logic [31:0] ev, clr, sw, m, v;
    if (!rstN) begin
      mGie = 0; mIer = 0; mStatus = 0; mSens = NM; mPrev = 0;
      mRdata = 0; mAnyPrev = 0; mIrqL = 0; mIrqP = 0;
      mBvalid = 0; mRvalid = 0;
    end else begin
      if (arvalid && !mRvalid) begin
        mRdata = regRead(araddr); mRvalid = 1;
      end else if (rready) begin
        mRvalid = 0;
      end
      any = mGie && ((mStatus & mIer) != 0);
      mIrqL = any;
      mIrqP = any && !mAnyPrev;
      mAnyPrev = any;
      ev = 0;
      for (int i = 0; i < N; i++) begin
        a = (irqSrc[i] == ACT[i]);
        if (mSens[i]) ev[i] = a && !mPrev[i];
        else ev[i] = a;
        mPrev[i] = a;
      end
      clr = 0; sw = 0;
      if (awvalid && wvalid && !mBvalid) begin
        m = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
        v = wdata & m & NM;
        case (awaddr[4:2])
          3'd0: if (wstrb[0]) mGie = wdata[0];
          3'd1: mIer = ((mIer & ~m) | v) & NM;
          3'd3: clr = v;
          3'd5: mSens = ((mSens & ~m) | v) & NM;
          3'd6: sw = v;
          default: ;
        endcase
        mBvalid = 1;
      end else if (bready) begin
        mBvalid = 0;
      end
      mStatus = ((mStatus & ~clr) | ev | sw) & NM;
    end
  end

  always @(negedge tb_ACLK) begin
    if (rstN) begin
      chk("irqLevel", irqL, mIrqL);
      chk("irqPulse", pIrq, mIrqP);
      chk("bvalid", bvalid, mBvalid);
      chk("rvalid", rvalid, mRvalid);
    end
    if (pIrq === 1'b1) pulseCnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge tb_ACLK);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1; bready = 1;
    @(negedge tb_ACLK);
    chk("awready", awready, 1);
    chk("wready", wready, 1);
    @(posedge tb_ACLK); #1;
    awvalid = 0; wvalid = 0;
    @(negedge tb_ACLK);
    chk("bresp", bresp, 0);
    @(posedge tb_ACLK); #1;
  endtask

  task automatic rd(input logic [4:0] a, input int hold,
                    output logic [31:0] obs);
    araddr = a; arvalid = 1; rready = (hold == 0);
    @(negedge tb_ACLK);
    chk("arready", arready, 1);
    @(posedge tb_ACLK); #1;
    arvalid = 0;
    @(negedge tb_ACLK);
    chk("rdata", rdata, mRdata);
    chk("rresp", rresp, 0);
    obs = rdata;
    for (int k = 0; k < hold; k++) begin
      @(posedge tb_ACLK);
      @(negedge tb_ACLK);
      chk("rdataHold", rdata, mRdata);
    end
    rready = 1;
    @(posedge tb_ACLK); #1;
  endtask

  task automatic clean();
    irqSrc = 0;
    wr(5'h00, 0, 4'hF);
    wr(5'h04, 0, 4'hF);
    wr(5'h14, NM, 4'hF);
    cyc(2);
    wr(5'h0C, 32'hFFFFFFFF, 4'hF);
  endtask

  task automatic readResetRegs(input string tag);
    logic [31:0] obs;
    for (int i = 0; i < 8; i++) begin
      logic [4:0] a;
      a = 5'(i * 4);
      rd(a, 0, obs);
      chk(tag, obs, (a == 5'h14) ? 32'hF : 32'h0);
    end
  endtask

  initial begin
    logic [31:0] obs;
    int base;
    nVec = 0; nErr = 0; pulseCnt = 0;
    rstN = 0; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0;
    wvalid = 0; bready = 1; araddr = 0; arvalid = 0; rready = 1;
    irqSrc = 0;
    repeat (3) @(posedge tb_ACLK);
    #1;
    chk("rstIrq", irqL, 0);
    chk("rstBvalid", bvalid, 0);
    chk("rstRvalid", rvalid, 0);
    chk("rstRdata", rdata, 0);
    rstN = 1;
    cyc(1);
    readResetRegs("rstReg");

    // edge source -> irq two cycles later, IACK clears
    wr(5'h00, 1, 4'hF);
    wr(5'h04, 1, 4'hF);
    irqSrc[0] = 1;
    cyc(1);
    irqSrc[0] = 0;
    chk("edgeIrqEarly", irqL, 0);
    cyc(1);
    chk("edgeIrq", irqL, 1);
    rd(5'h10, 0, obs);
    chk("edgePend", obs, 1);
    wr(5'h0C, 1, 4'hF);
    rd(5'h10, 0, obs);
    chk("iackPend", obs, 0);
    chk("iackIrq", irqL, 0);

    // level source survives IACK while held
    clean();
    wr(5'h14, 0, 4'hF);
    irqSrc[2] = 1;
    wr(5'h04, 4, 4'hF);
    wr(5'h00, 1, 4'hF);
    rd(5'h08, 0, obs);
    chk("lvlStatus", obs, 4);
    wr(5'h0C, 4, 4'hF);
    rd(5'h08, 0, obs);
    chk("lvlReassert", obs, 4);
    irqSrc[2] = 0;
    wr(5'h0C, 4, 4'hF);
    rd(5'h08, 0, obs);
    chk("lvlCleared", obs, 0);

    // software trigger, IER masks PEND, GIE gates irq
    wr(5'h04, 0, 4'hF);
    wr(5'h18, 32'hA, 4'hF);
    rd(5'h08, 0, obs);
    chk("swStatus", obs, 32'hA);
    rd(5'h10, 0, obs);
    chk("swPend0", obs, 0);
    chk("swIrq0", irqL, 0);
    wr(5'h04, 8, 4'hF);
    rd(5'h10, 0, obs);
    chk("swPend8", obs, 8);
    chk("swIrq1", irqL, 1);
    wr(5'h00, 0, 4'hF);
    cyc(1);
    chk("gieOff", irqL, 0);
    rd(5'h10, 2, obs);
    chk("gieOffPend", obs, 8);

    // edge and IACK on the same bit in the same cycle
    clean();
    wr(5'h18, 2, 4'hF);
    irqSrc[1] = 1;
    wr(5'h0C, 2, 4'hF);
    rd(5'h08, 0, obs);
    chk("setWins", obs & 32'h2, 2);
    irqSrc = 0;

    // pulse-mode instance: one pulse per rise of 'any'
    clean();
    wr(5'h04, 3, 4'hF);
    wr(5'h00, 1, 4'hF);
    base = pulseCnt;
    irqSrc[0] = 1; cyc(1); irqSrc[0] = 0;
    cyc(2);
    irqSrc[1] = 1; cyc(1); irqSrc[1] = 0;
    cyc(6);
    chk("onePulse", pulseCnt - base, 1);
    wr(5'h0C, 3, 4'hF);
    cyc(2);
    irqSrc[0] = 1; cyc(1); irqSrc[0] = 0;
    cyc(4);
    chk("secondPulse", pulseCnt - base, 2);

    // randomised traffic
    clean();
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) begin
        irqSrc = 4'($urandom);
        cyc(1);
      end else if (r <= 5) begin
        wr(5'($urandom_range(0, 7) * 4), $urandom, 4'($urandom));
      end else if (r <= 8) begin
        rd(5'($urandom_range(0, 7) * 4), $urandom_range(0, 2), obs);
      end else begin
        cyc($urandom_range(1, 4));
      end
    end

    // reset in the middle of a write response
    irqSrc = 0;
    wr(5'h04, 5, 4'hF);
    wr(5'h00, 1, 4'hF);
    wr(5'h18, 1, 4'hF);
    bready = 0;
    awaddr = 5'h04; wdata = 32'hF; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    @(posedge tb_ACLK); #1;
    @(negedge tb_ACLK);
    chk("midBvalid", bvalid, 1);
    #2;
    rstN = 0;
    #1;
    chk("rstBvalidNow", bvalid, 0);
    chk("rstAwready", awready, 0);
    chk("rstIrqNow", irqL, 0);
    awvalid = 0; wvalid = 0; bready = 1;
    cyc(2);
    rstN = 1;
    cyc(1);
    readResetRegs("postRst");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
